// File: rtl/snn_noc_pkg.sv
// Shared definitions for the spiking-network NoC receive path:
// address field layout, packet field offsets and the receiver FSM encoding.
package snn_noc_pkg;

   localparam int ADDR_W  = 12;
   localparam int IDX_W   = 4;
   localparam int NODE_W  = ADDR_W - IDX_W;

   // A packet is {src_addr, dst_addr}; dst occupies the low half.
   localparam int SRC_LSB = ADDR_W;
   localparam int DST_LSB = 0;

   typedef enum logic {
      S_FLUSH = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   // Node field: the upper ADDR_W-IDX_W bits of a neuron address.
   function automatic logic [NODE_W-1:0] node_of(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1:IDX_W];
   endfunction

   // Local neuron index: the low IDX_W bits of a neuron address.
   function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] addr);
      return addr[IDX_W-1:0];
   endfunction

endpackage

// File: rtl/spike_rx_fifo.sv
// Ingress FIFO for spike packets. Power-of-two depth, wrapping pointers,
// an occupancy counter one bit wider than the pointers, and a synchronous
// flush that empties the queue without touching the storage.
module spike_rx_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q,  count_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty = (count_q == {(PTR_W+1){1'b0}});
   assign rdata = mem_q[rd_ptr_q];

   // Qualify requests, advance pointers and occupancy, write the tail slot
   always_comb begin
      do_push_s = push && !full;
      do_pop_s  = pop && !empty;
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = (do_push_s && (wr_ptr_q == PTR_W'(i))) ? wdata : mem_q[i];
      end
      wr_ptr_d = do_push_s ? (wr_ptr_q + PTR_W'(1'b1)) : wr_ptr_q;
      rd_ptr_d = do_pop_s  ? (rd_ptr_q + PTR_W'(1'b1)) : rd_ptr_q;
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + (PTR_W+1)'(1'b1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1'b1);
         default: count_d = count_q;
      endcase
      if (flush) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {(PTR_W+1){1'b0}};
      end else begin
         count_d  = count_d;
      end
   end

   // Storage and pointer registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {(PTR_W+1){1'b0}};
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/spike_packet_receiver.sv
// Receive-side NoC interface for a cluster of local neurons. Packets are
// queued in an ingress FIFO; the head is decoded each cycle and either
// dropped (foreign node or out-of-range index), delivered into the
// addressed neuron's event slot, or held while that slot is still pending.
module spike_packet_receiver #(
   parameter int NUM_NEURONS = 10,
   parameter int ADDR_W      = 12,
   parameter int IDX_W       = 4,
   parameter int NODE_ID     = 0,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                          CLK,
   input  logic                          RESET_N,
   input  logic                          clear,
   input  logic                          pkt_valid,
   output logic                          pkt_ready,
   input  logic [2*ADDR_W-1:0]           pkt_data,
   output logic [NUM_NEURONS-1:0]        spike_valid,
   output logic [NUM_NEURONS*ADDR_W-1:0] spike_source,
   input  logic [NUM_NEURONS-1:0]        spike_ack,
   output logic                          drop_pulse,
   output logic [15:0]                   drop_count
);

   import snn_noc_pkg::*;

   localparam int PKT_W   = 2 * ADDR_W;
   localparam int NODE_BW = ADDR_W - IDX_W;

   state_t                 state_q, state_d;
   logic [NUM_NEURONS-1:0] spike_valid_q, spike_valid_d;
   logic [ADDR_W-1:0]      spike_src_q [NUM_NEURONS];
   logic [ADDR_W-1:0]      spike_src_d [NUM_NEURONS];
   logic                   drop_pulse_q, drop_pulse_d;
   logic [15:0]            drop_count_q, drop_count_d;

   logic                   fifo_full_s;
   logic                   fifo_empty_s;
   logic                   push_s;
   logic                   pop_s;
   logic [PKT_W-1:0]       head_s;
   logic [ADDR_W-1:0]      head_src_s;
   logic [ADDR_W-1:0]      head_dst_s;
   logic [NODE_BW-1:0]     head_node_s;
   logic [IDX_W-1:0]       head_idx_s;
   logic                   head_foreign_s;
   logic                   slot_busy_s;
   logic                   dispatch_ok_s;
   logic                   drop_s;
   logic                   deliver_s;
   logic [NUM_NEURONS-1:0] deliver_vec_s;
   logic                   pkt_ready_s;

   spike_rx_fifo #(
      .WIDTH (PKT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (RESET_N),
      .flush (clear),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (pkt_data),
      .rdata (head_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Decode the FIFO head and choose drop / deliver / hold for this cycle
   always_comb begin
      head_src_s     = head_s[PKT_W-1:ADDR_W];
      head_dst_s     = head_s[ADDR_W-1:0];
      head_node_s    = head_dst_s[ADDR_W-1:IDX_W];
      head_idx_s     = head_dst_s[IDX_W-1:0];
      head_foreign_s = (head_node_s != NODE_BW'(NODE_ID)) ||
                       (int'(head_idx_s) >= NUM_NEURONS);
      // Blocking uses the registered slot state, so an ack in this same
      // cycle does not let the head through until the next cycle.
      slot_busy_s = 1'b0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
         slot_busy_s = slot_busy_s | ((int'(head_idx_s) == n) & spike_valid_q[n]);
      end
      dispatch_ok_s = (state_q == S_RUN) && !clear && !fifo_empty_s;
      drop_s        = dispatch_ok_s && head_foreign_s;
      deliver_s     = dispatch_ok_s && !head_foreign_s && !slot_busy_s;
      pop_s         = drop_s || deliver_s;
      for (int n = 0; n < NUM_NEURONS; n++) begin
         deliver_vec_s[n] = deliver_s && (int'(head_idx_s) == n);
      end
      pkt_ready_s   = !fifo_full_s && !clear && (state_q != S_FLUSH);
      push_s        = pkt_valid && pkt_ready_s;
   end

   // Next-state logic: clear forces one flush cycle before running again
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = S_FLUSH;
      end else begin
         case (state_q)
            S_FLUSH: state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_FLUSH;
         endcase
      end
   end

   // Per-neuron event slots and drop accounting
   always_comb begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
         spike_valid_d[n] = clear ? 1'b0
                                  : (deliver_vec_s[n] | (spike_valid_q[n] & ~spike_ack[n]));
         spike_src_d[n]   = deliver_vec_s[n] ? head_src_s : spike_src_q[n];
      end
      drop_pulse_d = drop_s;
      drop_count_d = (drop_s && (drop_count_q != 16'hFFFF)) ? (drop_count_q + 16'd1)
                                                            : drop_count_q;
   end

   // State, slot and counter registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q       <= S_FLUSH;
         spike_valid_q <= {NUM_NEURONS{1'b0}};
         for (int n = 0; n < NUM_NEURONS; n++) begin
            spike_src_q[n] <= {ADDR_W{1'b0}};
         end
         drop_pulse_q  <= 1'b0;
         drop_count_q  <= 16'h0000;
      end else begin
         state_q       <= state_d;
         spike_valid_q <= spike_valid_d;
         for (int n = 0; n < NUM_NEURONS; n++) begin
            spike_src_q[n] <= spike_src_d[n];
         end
         drop_pulse_q  <= drop_pulse_d;
         drop_count_q  <= drop_count_d;
      end
   end

   // Flatten the slot sources onto the output bus
   always_comb begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
         spike_source[n*ADDR_W +: ADDR_W] = spike_src_q[n];
      end
   end

   assign pkt_ready   = pkt_ready_s;
   assign spike_valid = spike_valid_q;
   assign drop_pulse  = drop_pulse_q;
   assign drop_count  = drop_count_q;

endmodule
